fetch_issue_queue: RTL
======================

// Module: fetch_issue_queue
// PURPOSE
//  Producer end of the valid/allow stage handshake: a DEPTH-entry FIFO that buffers fetched
//  {pc,inst} words and presents them to the decode-stage register as valid_out/data_out.
//  The decode stage returns allow_in, its allow_out. An entry carrying a fetch exception
//  stops further enqueue until flush. Sits between fetch response logic and decode stage.
// PARAMETERS
//  DEPTH     4   entries; power of two, >= 2
//  WIDTH     64  payload bits ({pc[31:0], inst[31:0]})
//  NOP_DATA  '0  value driven on data_out while queue is empty
// PORTS
//  aclk       in   1              clock; all state updates on posedge
//  areset     in   1              synchronous, active-high reset
//  flush      in   1              discard all entries (branch redirect / exception)
//  in_valid   in   1              fetch offers an entry
//  in_data    in   WIDTH          fetched payload
//  in_exc     in   1              entry carries a fetch exception (e.g. ADEF)
//  in_ready   out  1              queue accepts in this cycle
//  valid_out  out  1              head entry valid towards decode stage
//  data_out   out  WIDTH          head payload; NOP_DATA when empty
//  exc_out    out  1              head entry exception flag; 0 when empty
//  allow_in   in   1              decode stage can take an entry this cycle
//  count      out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (areset=1 at posedge): count=0, rd/wr ptr=0, exc_lock=0 -> valid_out=0,
//   in_ready=1, data_out=NOP_DATA, exc_out=0. Storage array is not reset.
//  push = in_valid & in_ready; pop = valid_out & allow_in.
//  in_ready = (count != DEPTH) & ~exc_lock. It never depends on allow_in
//   (no comb path in->out). A full queue refuses input even if a pop occurs in the same cycle.
//  valid_out = (count != 0). data_out/exc_out come straight from the head register (no bypass).
//   Push-to-valid_out latency = 1 cycle.
//  Push: mem[wr_ptr] <= {in_exc,in_data}; wr_ptr wraps modulo DEPTH.
//  Pop: rd_ptr wraps modulo DEPTH.
//  Occupancy: push&pop -> count unchanged; push only -> +1; pop only -> -1.
//   count never exceeds DEPTH and never goes below 0.
//  exc_lock: set on push with in_exc=1, so in_ready=0 from the next cycle.
//   Entries already queued still drain in order. exc_lock clears only on flush/reset.
//  flush (level, 1 cycle sufficient): next cycle count=0, ptrs=0, exc_lock=0.
//   It overrides a same-cycle push (entry dropped). A same-cycle pop still counts as
//   accepted downstream; the decode stage flushes itself.
//  Priority: areset > flush > push/pop.
//  Holding valid_out=1 with allow_in=0: data_out/exc_out remain stable until pop or flush.
//  Reset mid-operation behaves as flush, plus a return to reset values.
// TESTING
//  1 Reset, then idle -> valid_out=0, in_ready=1, count=0, data_out=NOP_DATA.
//  2 Push 0x1C000000_02800400 with allow_in=1 -> valid_out=1 next cycle with that data;
//    popped that cycle; count back to 0.
//  3 allow_in=0, push 4 entries A..D -> count=4, in_ready=0. Offer E: not accepted.
//    Then allow_in=1 -> pops A,B,C,D in order, one per cycle.
//  4 count=2, push and pop in the same cycle, repeated 10 cycles -> count stays 2;
//    order is preserved across pointer wrap.
//  5 Push X (in_exc=1), then offer Y -> in_ready=0 and Y is refused. X pops with exc_out=1.
//    After flush, in_ready=1.
//  6 count=3 with flush and push asserted together -> next cycle count=0, valid_out=0;
//    the pushed entry never appears on data_out.

Source files
------------

// File: rtl/fetch_issue_queue.sv
// Fetch-to-decode issue FIFO: buffers {pc,inst} words and presents the head entry
// under the valid/allow handshake. An excepting entry blocks further enqueue until flush.
module fetch_issue_queue #(
  parameter int unsigned      DEPTH    = 4,
  parameter int unsigned      WIDTH    = 64,
  parameter logic [WIDTH-1:0] NOP_DATA = '0
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_exc,
  output logic                     in_ready,
  output logic                     valid_out,
  output logic [WIDTH-1:0]         data_out,
  output logic                     exc_out,
  input  logic                     allow_in,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               exc_lock_q, exc_lock_d;
  logic               push, pop;
  logic [WIDTH:0]     head;

  // in_ready is a pure function of registered state, so allow_in never reaches it.
  assign in_ready  = (count_q != FULL) && !exc_lock_q;
  assign valid_out = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = valid_out && allow_in;
  assign head      = mem_q[rd_ptr_q];
  assign data_out  = valid_out ? head[WIDTH-1:0] : NOP_DATA;
  assign exc_out   = valid_out && head[WIDTH];
  assign count     = count_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    exc_lock_d = exc_lock_q;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      exc_lock_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (in_exc) exc_lock_d = 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      exc_lock_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      exc_lock_q <= exc_lock_d;
    end
  end

  // Storage is not reset; a flushed or reset push is simply not written.
  always_ff @(posedge aclk) begin
    if (push && !flush && !areset) mem_q[wr_ptr_q] <= {in_exc, in_data};
  end

endmodule
